// File: rtl/match_controller_if.sv
// Match controller signal bundle: player/game inputs toward the controller and
// the playfield/scoreboard outputs it produces.
interface match_controller_if;
  logic       start;
  logic       leftWin;
  logic       rightWin;
  logic       softReset;
  logic       playEnable;
  logic [2:0] leftScore;
  logic [2:0] rightScore;
  logic       gameOver;
  logic [1:0] winner;

  // Driver side: supplies start and the edge-light win reports.
  modport master (
    output start,
    output leftWin,
    output rightWin,
    input  softReset,
    input  playEnable,
    input  leftScore,
    input  rightScore,
    input  gameOver,
    input  winner
  );

  // Controller side.
  modport slave (
    input  start,
    input  leftWin,
    input  rightWin,
    output softReset,
    output playEnable,
    output leftScore,
    output rightScore,
    output gameOver,
    output winner
  );
endinterface

// File: rtl/match_controller.sv
// Match controller: sequences a two-player light game through idle, play,
// post-point pause and game-over, keeping score and reporting the winner.
module match_controller #(
  parameter int unsigned MAX_SCORE    = 7,
  parameter int unsigned PAUSE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  match_controller_if.slave mc
);

  localparam logic [2:0] MaxScore  = 3'(MAX_SCORE);
  // Counter runs PAUSE_CYCLES-1 down to 0, so the pause spans PAUSE_CYCLES cycles.
  localparam logic [7:0] PauseLoad = 8'(PAUSE_CYCLES - 1);

  localparam logic [1:0] WinNone  = 2'b00;
  localparam logic [1:0] WinLeft  = 2'b01;
  localparam logic [1:0] WinRight = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StPoint,
    StOver
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] left_score_q, left_score_d;
  logic [2:0] right_score_q, right_score_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] pause_q, pause_d;

  logic left_only, right_only, both_win;

  assign left_only  = mc.leftWin & ~mc.rightWin;
  assign right_only = mc.rightWin & ~mc.leftWin;
  assign both_win   = mc.leftWin & mc.rightWin;

  // State, score, winner and pause registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      left_score_q  <= 3'd0;
      right_score_q <= 3'd0;
      winner_q      <= WinNone;
      pause_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      winner_q      <= winner_d;
      pause_q       <= pause_d;
    end
  end

  // Next-state logic; scores only move in play, win inputs ignored elsewhere.
  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    winner_d      = winner_q;
    pause_d       = pause_q;

    unique case (state_q)
      StIdle: begin
        if (mc.start) begin
          state_d = StPlay;
        end
      end

      StPlay: begin
        if (left_only) begin
          // Saturate defensively; in play the score is always below the target.
          if (left_score_q < MaxScore) begin
            left_score_d = left_score_q + 3'd1;
          end
          if (left_score_d == MaxScore) begin
            state_d  = StOver;
            winner_d = WinLeft;
          end else begin
            state_d = StPoint;
            pause_d = PauseLoad;
          end
        end else if (right_only) begin
          if (right_score_q < MaxScore) begin
            right_score_d = right_score_q + 3'd1;
          end
          if (right_score_d == MaxScore) begin
            state_d  = StOver;
            winner_d = WinRight;
          end else begin
            state_d = StPoint;
            pause_d = PauseLoad;
          end
        end else if (both_win) begin
          // Simultaneous hits are a replayed point: pause, no score change.
          state_d = StPoint;
          pause_d = PauseLoad;
        end
      end

      StPoint: begin
        if (pause_q == 8'd0) begin
          state_d = StPlay;
        end else begin
          pause_d = pause_q - 8'd1;
        end
      end

      StOver: begin
        if (mc.start) begin
          state_d       = StIdle;
          left_score_d  = 3'd0;
          right_score_d = 3'd0;
          winner_d      = WinNone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from the state register alone.
  always_comb begin
    mc.softReset  = 1'b1;
    mc.playEnable = 1'b0;
    mc.gameOver   = 1'b0;
    unique case (state_q)
      StIdle:  mc.softReset = 1'b1;
      StPlay: begin
        mc.softReset  = 1'b0;
        mc.playEnable = 1'b1;
      end
      StPoint: mc.softReset = 1'b1;
      StOver:  mc.gameOver  = 1'b1;
      default: mc.softReset = 1'b1;
    endcase
  end

  assign mc.leftScore  = left_score_q;
  assign mc.rightScore = right_score_q;
  assign mc.winner     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters (7 points, 4-cycle pause).
module tb_match_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  match_controller_if mc_if ();

  match_controller #(
    .MAX_SCORE    (7),
    .PAUSE_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .mc    (mc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic sr, input logic pe, input logic go);
    check_val({tag, "_softReset"}, 8'(mc_if.softReset), 8'(sr));
    check_val({tag, "_playEnable"}, 8'(mc_if.playEnable), 8'(pe));
    check_val({tag, "_gameOver"}, 8'(mc_if.gameOver), 8'(go));
  endtask

  task automatic expect_score(input string tag, input int l, input int r, input int w);
    check_val({tag, "_left"}, 8'(mc_if.leftScore), 8'(l));
    check_val({tag, "_right"}, 8'(mc_if.rightScore), 8'(r));
    check_val({tag, "_winner"}, 8'(mc_if.winner), 8'(w));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    mc_if.start = 1'b0;
    mc_if.leftWin = 1'b0;
    mc_if.rightWin = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state: IDLE.
    expect_state("rst", 1'b1, 1'b0, 1'b0);
    expect_score("rst", 0, 0, 0);

    // Win pulses in IDLE are ignored.
    mc_if.leftWin = 1'b1;
    mc_if.rightWin = 1'b1;
    step();
    mc_if.leftWin = 1'b0;
    mc_if.rightWin = 1'b0;
    expect_state("idle_win", 1'b1, 1'b0, 1'b0);
    expect_score("idle_win", 0, 0, 0);

    // Start -> PLAY next cycle.
    mc_if.start = 1'b1;
    step();
    expect_state("start", 1'b0, 1'b1, 1'b0);
    expect_score("start", 0, 0, 0);
    // Start held in PLAY changes nothing.
    step();
    mc_if.start = 1'b0;
    expect_state("play_start", 1'b0, 1'b1, 1'b0);

    // Left point: POINT for 4 cycles, win inputs ignored while paused.
    mc_if.leftWin = 1'b1;
    step();
    mc_if.leftWin = 1'b0;
    expect_state("lpt1", 1'b1, 1'b0, 1'b0);
    expect_score("lpt1", 1, 0, 0);
    mc_if.rightWin = 1'b1;
    mc_if.start = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      expect_state($sformatf("lpt%0d", i), 1'b1, 1'b0, 1'b0);
      expect_score($sformatf("lpt%0d", i), 1, 0, 0);
    end
    mc_if.rightWin = 1'b0;
    mc_if.start = 1'b0;
    step();
    expect_state("lpt_back", 1'b0, 1'b1, 1'b0);

    // Both wins at once: replayed point, scores unchanged.
    mc_if.leftWin = 1'b1;
    mc_if.rightWin = 1'b1;
    step();
    mc_if.leftWin = 1'b0;
    mc_if.rightWin = 1'b0;
    expect_state("both1", 1'b1, 1'b0, 1'b0);
    expect_score("both1", 1, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_val($sformatf("both%0d_softReset", i), 8'(mc_if.softReset), 8'd1);
    end
    step();
    expect_state("both_back", 1'b0, 1'b1, 1'b0);
    expect_score("both_back", 1, 0, 0);

    // Right player takes seven points.
    for (int i = 1; i <= 7; i++) begin
      mc_if.rightWin = 1'b1;
      step();
      mc_if.rightWin = 1'b0;
      check_val($sformatf("r%0d_score", i), 8'(mc_if.rightScore), 8'(i));
      if (i < 7) begin
        repeat (3) step();
        check_val($sformatf("r%0d_pause_end", i), 8'(mc_if.playEnable), 8'd0);
        step();
        check_val($sformatf("r%0d_resume", i), 8'(mc_if.playEnable), 8'd1);
      end
    end
    expect_state("over", 1'b1, 1'b0, 1'b1);
    expect_score("over", 1, 7, 2);

    // Wins in OVER change nothing.
    mc_if.leftWin = 1'b1;
    step();
    mc_if.leftWin = 1'b0;
    mc_if.rightWin = 1'b1;
    step();
    mc_if.rightWin = 1'b0;
    expect_state("over_hold", 1'b1, 1'b0, 1'b1);
    expect_score("over_hold", 1, 7, 2);

    // Start acknowledges game over -> IDLE, cleared.
    mc_if.start = 1'b1;
    step();
    mc_if.start = 1'b0;
    expect_state("ack", 1'b1, 1'b0, 1'b0);
    expect_score("ack", 0, 0, 0);

    // Reset in the 2nd POINT cycle abandons the pause.
    mc_if.start = 1'b1;
    step();
    mc_if.start = 1'b0;
    mc_if.leftWin = 1'b1;
    step();
    mc_if.leftWin = 1'b0;
    expect_score("mid_pt1", 1, 0, 0);
    step();
    check_val("mid_pt2_softReset", 8'(mc_if.softReset), 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_state("mid_rst", 1'b1, 1'b0, 1'b0);
    expect_score("mid_rst", 0, 0, 0);
    // Still idle a few cycles later: no stale pause returns it to PLAY.
    repeat (4) step();
    expect_state("mid_rst_idle", 1'b1, 1'b0, 1'b0);
    mc_if.start = 1'b1;
    step();
    mc_if.start = 1'b0;
    expect_state("restart", 1'b0, 1'b1, 1'b0);

    // Left player wins a game: winner code 01.
    for (int i = 1; i <= 7; i++) begin
      mc_if.leftWin = 1'b1;
      step();
      mc_if.leftWin = 1'b0;
      if (i < 7) repeat (4) step();
    end
    expect_state("lover", 1'b1, 1'b0, 1'b1);
    expect_score("lover", 7, 0, 1);

    // Reset takes priority in OVER even with start high.
    mc_if.start = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mc_if.start = 1'b0;
    expect_state("over_rst", 1'b1, 1'b0, 1'b0);
    expect_score("over_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 7, points needed to win; legal range 1..7.
REQ-002 SHALL have parameter PAUSE_CYCLES, default 4, cycles the lights are held at center after each point; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level, sampled each cycle; begins a match from IDLE and acknowledges game over in OVER.
REQ-006 SHALL have port leftWin  input  1  left edge light reports the left player scored.
REQ-007 SHALL have port rightWin  input  1  right edge light reports the right player scored.
REQ-008 SHALL have port softReset  output  1  drives softReset of every light cell; forces the playfield back to center.
REQ-009 SHALL have port playEnable  output  1  high only while player key presses are allowed to reach the playfield.
REQ-010 SHALL have port leftScore  output  3  left player point count.
REQ-011 SHALL have port rightScore  output  3  right player point count.
REQ-012 SHALL have port gameOver  output  1  high while in OVER.
REQ-013 SHALL have port winner  output  2  2'b01 left won, 2'b10 right won, 2'b00 no winner yet.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, PLAY, POINT and OVER; softReset, playEnable and gameOver SHALL decode from the state register only.
REQ-015 SHALL drive these outputs per state: IDLE softReset=1, playEnable=0; PLAY softReset=0, playEnable=1; POINT softReset=1, playEnable=0; OVER softReset=1, playEnable=0, gameOver=1.
REQ-016 IDLE: start=1 -> PLAY on the next edge; otherwise stay in IDLE.
REQ-017 PLAY, leftWin=1 and rightWin=0: SHALL increment leftScore by 1 on that edge; if the new value equals MAX_SCORE -> OVER with winner=2'b01, otherwise -> POINT.
REQ-018 PLAY, rightWin=1 and leftWin=0: mirror of REQ-017, with rightScore and winner=2'b10.
REQ-019 PLAY, leftWin=1 and rightWin=1 in the same cycle: SHALL leave both scores unchanged and go to POINT (replayed point).
REQ-020 PLAY, neither win input high: stay in PLAY.
REQ-021 On entry to POINT, SHALL load the pause counter so that POINT lasts exactly PAUSE_CYCLES cycles, then go to PLAY.
REQ-022 In POINT, OVER and IDLE, leftWin and rightWin SHALL be ignored; scores SHALL never change outside PLAY.
REQ-023 Latency: a win input sampled high at PLAY cycle N gives updated score and softReset=1 from cycle N+1; for a non-final point, playEnable returns to 1 at cycle N+1+PAUSE_CYCLES.
REQ-024 OVER: scores and winner SHALL hold; start=1 -> IDLE, clearing leftScore, rightScore and winner to 0 on that edge.
REQ-025 In PLAY and POINT, start SHALL be ignored.
REQ-026 Scores SHALL never exceed MAX_SCORE and SHALL never wrap.

Reset
REQ-027 With reset=1 at a rising edge, SHALL enter IDLE with leftScore=0, rightScore=0, winner=2'b00, pause counter=0, softReset=1, playEnable=0, gameOver=0.
REQ-028 Reset SHALL take priority over every other input in every state, including mid-POINT and in OVER.

Verification
REQ-029 reset, then start pulse -> PLAY next cycle, playEnable=1, softReset=0, scores 0/0.
REQ-030 In PLAY, 1-cycle leftWin -> next cycle leftScore=1, softReset=1 for exactly 4 cycles (default), then playEnable=1.
REQ-031 leftWin and rightWin together in PLAY -> scores unchanged, POINT for 4 cycles, back to PLAY.
REQ-032 Right player scores 7 points -> after 7th: rightScore=7, winner=2'b10, gameOver=1; further win pulses change nothing; start -> IDLE, scores 0, winner 2'b00.
REQ-033 reset asserted in the 2nd POINT cycle -> next cycle IDLE, all scores 0, pause abandoned.
REQ-034 Win pulses during POINT and IDLE, and start during PLAY -> no score or state change.
